fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types, default sizes and the bit-reversal helper for the FFT sequencer.
package fft_pkg;

    localparam int unsigned DEF_BIT_WIDTH = 16;
    localparam int unsigned DEF_N         = 9;
    localparam int unsigned DEF_BF_LAT    = 4;
    localparam int unsigned MAX_N         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_UNLOAD
    } fft_state_e;

    // Reverse the low n bits of v (n <= MAX_N); upper bits of the result are zero.
    function automatic logic [MAX_N-1:0] bit_reverse(input logic [MAX_N-1:0] v,
                                                     input int unsigned      n);
        logic [MAX_N-1:0] r;
        r = {<<{v}};
        return r >> (MAX_N - n);
    endfunction

endpackage

// File: rtl/fft_sequencer.sv
// Frame sequencer for an in-place FFT: loads samples bit-reversed, runs the address
// generator, waits out the butterfly pipeline and streams results in natural order.
// Optional saturating overrun counter enabled by FFT_SEQ_OVERRUN_CNT_EN.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int unsigned N         = DEF_N,
    parameter int unsigned BF_LAT    = DEF_BF_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    input  logic                 s_valid,
    input  logic [BIT_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 ld_we,
    output logic [N-1:0]         ld_addr,
    output logic [BIT_WIDTH-1:0] ld_data,
    output logic                 fft_clr,
    output logic                 fft_enable,
    input  logic                 fft_done,
    output logic [N-1:0]         rd_addr,
    output logic                 rd_bank,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_index,
    output logic                 frame_done
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]          overrun_cnt
`endif
);

    localparam int unsigned NPTS       = 1 << N;
    localparam logic [N:0]  LAST_CNT   = (N+1)'(NPTS - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(BF_LAT - 1);

    fft_state_e             state_q, state_d;
    logic [N:0]             smp_q, smp_d;
    logic [N:0]             idx_q, idx_d;
    logic [3:0]             drain_q, drain_d;
    logic                   busy_q, busy_d;
    logic                   s_ready_q, s_ready_d;
    logic                   ld_we_q, ld_we_d;
    logic [N-1:0]           ld_addr_q, ld_addr_d;
    logic [BIT_WIDTH-1:0]   ld_data_q, ld_data_d;
    logic                   fft_clr_q, fft_clr_d;
    logic                   fft_enable_q, fft_enable_d;
    logic                   m_valid_q, m_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   s_acc, m_acc;

    assign s_acc = s_valid && s_ready_q;
    assign m_acc = m_valid_q && m_ready;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            smp_q        <= '0;
            idx_q        <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            ld_we_q      <= 1'b0;
            ld_addr_q    <= '0;
            ld_data_q    <= '0;
            fft_clr_q    <= 1'b0;
            fft_enable_q <= 1'b0;
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
            ld_we_q      <= ld_we_d;
            ld_addr_q    <= ld_addr_d;
            ld_data_q    <= ld_data_d;
            fft_clr_q    <= fft_clr_d;
            fft_enable_q <= fft_enable_d;
            m_valid_q    <= m_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // fft_done only counts once the address generator is actually running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)                        state_d = ST_LOAD;
            ST_LOAD:    if (s_acc && smp_q == LAST_CNT)   state_d = ST_COMPUTE;
            ST_COMPUTE: if (fft_done && fft_enable_q)     state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_q == DRAIN_LAST)        state_d = ST_UNLOAD;
            ST_UNLOAD:  if (m_acc && idx_q == LAST_CNT)   state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    // Level outputs follow the next state so they line up with state_q after the edge
    always_comb begin
        smp_d        = smp_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        ld_we_d      = 1'b0;
        ld_addr_d    = ld_addr_q;
        ld_data_d    = ld_data_q;
        fft_clr_d    = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        s_ready_d    = (state_d == ST_LOAD);
        m_valid_d    = (state_d == ST_UNLOAD);
        fft_enable_d = (state_q == ST_COMPUTE) && (state_d == ST_COMPUTE);
        case (state_q)
            ST_IDLE: begin
                smp_d = '0;
                idx_d = '0;
            end
            ST_LOAD: begin
                if (s_acc) begin
                    smp_d     = smp_q + (N+1)'(1);
                    ld_we_d   = 1'b1;
                    ld_data_d = s_data;
                    ld_addr_d = N'(bit_reverse(MAX_N'(smp_q[N-1:0]), N));
                end
                fft_clr_d = (state_d == ST_COMPUTE);
            end
            ST_COMPUTE: drain_d = '0;
            ST_DRAIN:   drain_d = drain_q + 4'd1;
            ST_UNLOAD: begin
                if (m_acc) idx_d = idx_q + (N+1)'(1);
                frame_done_d = (state_d == ST_IDLE);
            end
            default: ;
        endcase
    end

    assign busy       = busy_q;
    assign s_ready    = s_ready_q;
    assign ld_we      = ld_we_q;
    assign ld_addr    = ld_addr_q;
    assign ld_data    = ld_data_q;
    assign fft_clr    = fft_clr_q;
    assign fft_enable = fft_enable_q;
    assign rd_addr    = idx_q[N-1:0];
    assign rd_bank    = 1'(N % 2);
    assign m_valid    = m_valid_q;
    assign m_index    = idx_q[N-1:0];
    assign frame_done = frame_done_q;

`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic [15:0] overrun_q;

    // Cycles where a sample was offered but not taken; saturates, cleared by reset only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (s_valid && !s_ready_q && overrun_q != 16'hFFFF) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: random frames checked against a bin-order model.
module tb_fft_sequencer;

    localparam int BW   = 16;
    localparam int NB   = 9;
    localparam int LAT  = 4;
    localparam int NPTS = 512;
    localparam logic EXP_BANK = 1'(NB % 2);

    logic          clk = 1'b0;
    logic          reset, start, s_valid, fft_done, m_ready;
    logic [BW-1:0] s_data;
    logic          busy, s_ready, ld_we, fft_clr, fft_enable, rd_bank, m_valid, frame_done;
    logic [NB-1:0] ld_addr, rd_addr, m_index;
    logic [BW-1:0] ld_data;
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [NB-1:0] wr_addr_q[$];
    logic [BW-1:0] wr_data_q[$];
    int            acc_q[$];
    int            clr_cnt = 0;
    int            fd_cnt  = 0;
    int            rd_bad  = 0;

    fft_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .fft_clr(fft_clr), .fft_enable(fft_enable), .fft_done(fft_done),
        .rd_addr(rd_addr), .rd_bank(rd_bank), .m_valid(m_valid), .m_ready(m_ready),
        .m_index(m_index), .frame_done(frame_done)
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Passive observer on the falling edge, where every DUT output is settled
    always @(negedge clk) begin
        if (ld_we) begin
            wr_addr_q.push_back(ld_addr);
            wr_data_q.push_back(ld_data);
        end
        if (fft_clr) clr_cnt++;
        if (frame_done) fd_cnt++;
        if (m_valid && m_ready) begin
            acc_q.push_back(int'(m_index));
            if (rd_addr !== m_index || rd_bank !== EXP_BANK) rd_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_bitrev(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < NB; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; fft_done = 1'b0; m_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, s_ready, ld_we, fft_clr, fft_enable, m_valid, frame_done} !== 7'b0)
            begin n_fail++; $display("FAIL reset_flags got %b want 0", {busy, s_ready, ld_we, fft_clr, fft_enable, m_valid, frame_done}); end
        n_checks++;
        if ({ld_addr, rd_addr, m_index} !== '0 || ld_data !== '0)
            begin n_fail++; $display("FAIL reset_words got %h/%h/%h/%h want 0", ld_addr, rd_addr, m_index, ld_data); end
        n_checks++;
        if (rd_bank !== EXP_BANK) begin n_fail++; $display("FAIL reset_bank got %b want %b", rd_bank, EXP_BANK); end
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold busy got %b want 0", busy); end
    endtask

    task automatic run_frame(input string name, input bit gaps, input int hold, input bit ovr,
                             input bit rand_ready, input bit noise, input bit hold_start);
        int            exp_addr[$];
        logic [BW-1:0] exp_data[$];
        int            k, guard, t;
        bit            acc, last_acc, ok, en_ok, quiet_ok;
        logic [15:0]   ovr0;
        wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
        clr_cnt = 0; fd_cnt = 0; rd_bad = 0; ovr0 = '0;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        n_checks++;
        if ({busy, s_ready} !== 2'b11) begin n_fail++; $display("FAIL %s load_entry got %b want 11", name, {busy, s_ready}); end
        k = 0; guard = 0;
        while (k < NPTS && guard < 20000) begin
            s_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data   = BW'($urandom);
            fft_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            acc = s_valid && s_ready;
            if (acc) begin
                exp_addr.push_back(ref_bitrev(k));
                exp_data.push_back(s_data);
                k++;
            end
            tick(); guard++;
        end
        s_valid = 1'b0; fft_done = 1'b0;
        n_checks++;
        if (k != NPTS) begin n_fail++; $display("FAIL %s load_timeout got %0d samples want %0d", name, k, NPTS); return; end
        n_checks++;
        if ({ld_we, fft_clr, fft_enable, s_ready} !== 4'b1100)
            begin n_fail++; $display("FAIL %s final_write got %b want 1100", name, {ld_we, fft_clr, fft_enable, s_ready}); end
        tick();
        n_checks++;
        if ({ld_we, fft_clr, fft_enable, busy} !== 4'b0011)
            begin n_fail++; $display("FAIL %s enable_rise got %b want 0011", name, {ld_we, fft_clr, fft_enable, busy}); end
        ok = (wr_addr_q.size() == NPTS);
        for (int i = 0; i < NPTS && ok; i++)
            if (wr_addr_q[i] !== NB'(exp_addr[i]) || wr_data_q[i] !== exp_data[i]) begin
                ok = 1'b0;
                $display("FAIL %s load_map idx %0d got %h:%h want %h:%h", name, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
            end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s load_writes got %0d writes want %0d matching", name, wr_addr_q.size(), NPTS); end
        n_checks++;
        if (wr_addr_q.size() != NPTS || wr_addr_q[1] !== 9'h100 || wr_addr_q[NPTS-1] !== 9'h1FF)
            begin n_fail++; $display("FAIL %s bitrev_corners got size %0d want 0x100/0x1FF", name, wr_addr_q.size()); end
        n_checks++;
        if (clr_cnt != 1) begin n_fail++; $display("FAIL %s clr_pulses got %0d want 1", name, clr_cnt); end
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        ovr0 = overrun_cnt;
`endif
        en_ok = 1'b1; quiet_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (fft_enable !== 1'b1) en_ok = 1'b0;
            if (s_ready !== 1'b0 || ld_we !== 1'b0) quiet_ok = 1'b0;
            s_valid = ovr;
            tick();
        end
        s_valid = 1'b0;
        if (fft_enable !== 1'b1) en_ok = 1'b0;
        if (s_ready !== 1'b0 || ld_we !== 1'b0) quiet_ok = 1'b0;
        n_checks++;
        if (!en_ok) begin n_fail++; $display("FAIL %s enable_hold got drop want steady 1", name); end
        n_checks++;
        if (!quiet_ok) begin n_fail++; $display("FAIL %s compute_quiet got s_ready/ld_we activity want none", name); end
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        if (ovr) begin
            n_checks++;
            if (overrun_cnt - ovr0 !== 16'(hold))
                begin n_fail++; $display("FAIL %s overrun got %0d want %0d", name, overrun_cnt - ovr0, hold); end
        end
`endif
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_checks++;
        if ({fft_enable, busy, m_valid} !== 3'b010)
            begin n_fail++; $display("FAIL %s enable_drop got %b want 010", name, {fft_enable, busy, m_valid}); end
        t = 1;
        while (!m_valid && t < 100) begin tick(); t++; end
        n_checks++;
        if (t != LAT + 1) begin n_fail++; $display("FAIL %s drain_len got %0d want %0d", name, t - 1, LAT); end
        guard = 0; last_acc = 1'b0;
        while (guard < 5000) begin
            m_ready  = rand_ready ? 1'($urandom_range(0, 1)) : (guard % 2 == 0);
            last_acc = m_valid && m_ready && (m_index == NB'(NPTS - 1));
            tick(); guard++;
            if (last_acc) break;
        end
        m_ready = 1'b0;
        n_checks++;
        if (!last_acc) begin n_fail++; $display("FAIL %s unload_timeout got no final accept want index %0d", name, NPTS - 1); end
        n_checks++;
        if ({frame_done, m_valid, busy} !== 3'b100)
            begin n_fail++; $display("FAIL %s frame_end got %b want 100", name, {frame_done, m_valid, busy}); end
        tick();
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got %b want 0", name, frame_done); end
        n_checks++;
        if ({busy, s_ready} !== (hold_start ? 2'b11 : 2'b00))
            begin n_fail++; $display("FAIL %s after_frame got %b want %b", name, {busy, s_ready}, hold_start ? 2'b11 : 2'b00); end
        ok = (acc_q.size() == NPTS);
        for (int i = 0; i < NPTS && ok; i++) if (acc_q[i] != i) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s bin_order got %0d accepts want 0..%0d once each", name, acc_q.size(), NPTS - 1); end
        n_checks++;
        if (fd_cnt != 1) begin n_fail++; $display("FAIL %s done_count got %0d want 1", name, fd_cnt); end
        n_checks++;
        if (rd_bad != 0) begin n_fail++; $display("FAIL %s rd_addr_bank got %0d bad beats want 0", name, rd_bad); end
    endtask

    task automatic test_back_to_back();
        run_frame("b2b", 1'b1, 300, 1'b0, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [BW-1:0] d;
        int            fd0;
        if (!busy) begin start = 1'b1; tick(); start = 1'b0; end
        for (int i = 0; i < 200; i++) begin
            s_valid = 1'b1; s_data = BW'($urandom);
            tick();
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, s_ready, ld_we, fft_clr, fft_enable, m_valid, frame_done} !== 7'b0 || ld_addr !== '0 || ld_data !== '0)
            begin n_fail++; $display("FAIL abort_outputs got %b/%h/%h want 0", {busy, s_ready, ld_we, fft_clr, fft_enable, m_valid, frame_done}, ld_addr, ld_data); end
        wr_addr_q.delete(); wr_data_q.delete();
        fd0 = fd_cnt;
        tick(); tick(); tick();
        reset = 1'b0; s_valid = 1'b0;
        tick();
        n_checks++;
        if (wr_addr_q.size() != 0 || fd_cnt != fd0 || busy !== 1'b0 || fft_enable !== 1'b0)
            begin n_fail++; $display("FAIL abort_quiet got %0d writes %0d dones busy %b want 0/0/0", wr_addr_q.size(), fd_cnt - fd0, busy); end
        start = 1'b1; tick(); start = 1'b0;
        d = BW'($urandom);
        s_valid = 1'b1; s_data = d;
        tick();
        s_valid = 1'b0;
        n_checks++;
        if (ld_we !== 1'b1 || ld_addr !== '0 || ld_data !== d)
            begin n_fail++; $display("FAIL restart_load got %b/%h/%h want 1/000/%h", ld_we, ld_addr, ld_data, d); end
        tick();
        n_checks++;
        if (ld_we !== 1'b0) begin n_fail++; $display("FAIL restart_single got %b want 0", ld_we); end
    endtask

    initial begin
        test_reset();
        run_frame("basic", 1'b0, 2303, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("overrun", 1'b1, 1000, 1'b1, 1'b1, 1'b1, 1'b0);
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
